gshare_ongorucu: RTL and testbench
==================================

# gshare_ongorucu

Gshare branch predictor for the fetch stage of the RV32 core: same fetch/execute port set that the predictor wrapper bench drives. Produces a same-cycle taken/target prediction for the instruction at fetch and trains on execute-stage resolution reports. Conditional branches use a global-history-indexed 2-bit counter table, JAL is always taken, and JALR uses a small direct-mapped BTB. A speculative history register is checkpointed per fetched conditional branch and repaired on every resolution report.

## Interface
- BHT_ENTRIES, 64: number of 2-bit counters (power of 2); IDX = log2(BHT_ENTRIES).
- BTB_ENTRIES, 8: JALR target buffer entries (power of 2); BIDX = log2(BTB_ENTRIES).
- CKPT_DEPTH, 4: history checkpoint queue depth.

- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- getir_ps  in  32  fetch PC.
- getir_buyruk  in  32  fetch instruction.
- getir_gecerli  in  1  fetch slot valid.
- yurut_ps  in  32  resolved branch PC.
- yurut_buyruk  in  32  resolved branch instruction.
- yurut_dallan  in  1  actual direction.
- yurut_dallan_ps  in  32  actual target.
- yurut_gecerli  in  1  resolution report valid (asserted on mispredict; pipeline flushes that cycle).
- sonuc_dallan  out  1  predicted taken (combinational).
- sonuc_dallan_ps  out  32  predicted target (combinational).

## Operation
- Decode on opcode [6:0]: 1100011 = BR (conditional), 1101111 = JAL, 1100111 = JALR; anything else = non-branch.
- Immediates: B = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}; J = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}. Targets = getir_ps + imm, mod 2^32.
- Fetch index: idx = getir_ps[IDX+1:2] XOR ghr (ghr is IDX bits).
- Prediction, with getir_gecerli=1:
  - BR: sonuc_dallan = bht[idx][1]; target = PC + B-imm.
  - JAL: taken; target = PC + J-imm.
  - JALR: taken iff BTB hit (valid and tag = getir_ps[31:BIDX+2]); target = BTB data.
  - Outputs are 1/target on taken, otherwise 0/0.
- getir_gecerli=0 or non-branch: outputs 0 and 0.
- Speculative history, on getir_gecerli and BR, no yurut_gecerli in the same cycle:
  - Push {getir_ps, ghr} onto the checkpoint queue. When the queue is full, the oldest entry is dropped.
  - Then ghr <= {ghr[IDX-2:0], sonuc_dallan}.
- Resolution, on yurut_gecerli:
  - Search the queue oldest-first for PC == yurut_ps. On a match, hist = the stored ghr; on a miss, hist = current ghr.
  - BR: the counter at index yurut_ps[IDX+1:2] XOR hist saturates toward yurut_dallan (3 stays 3 on taken, 0 stays 0 on not-taken). Then ghr <= {hist[IDX-2:0], yurut_dallan}.
  - JALR: the BTB entry at yurut_ps[BIDX+1:2] is written with valid=1, tag, and yurut_dallan_ps. ghr <= hist.
  - JAL and other opcodes: ghr <= hist; no table write.
  - The checkpoint queue is cleared in all cases.
- Simultaneous fetch and resolution: the resolution wins. The fetch push and fetch history shift are discarded. Prediction that cycle uses pre-update state.

## Timing
- Prediction has zero latency: combinational from getir_* and registered state.
- Table, BTB, ghr and queue updates take effect at the next posedge; a fetch in the following cycle sees the new value.
- Reset (rstn=0 at posedge):
  - All counters = 01 (weakly not-taken), ghr = 0, queue empty, all BTB entries invalid.
  - Outputs consequently 0/0 for BR and JALR, 1/target for JAL.
  - Reset mid-operation discards all queued checkpoints in the same edge.
- No backpressure; one fetch and one resolution are accepted per cycle.

## Test plan
- After reset: fetch BR at 0x100, instr 0x00000463 (beq x0,x0,+8) -> sonuc_dallan=0, sonuc_dallan_ps=0; ghr becomes 0 after the shift.
- Training: report yurut_gecerli with 0x100 BR taken, twice -> counter goes 01→10→11. The next fetch of 0x100 with matching history gives 1 / 0x108.
- JAL: fetch 0x200, instr 0x0100006F (jal +16), from any state -> 1 / 0x210; no history change.
- JALR: fetch 0x300, instr 0x00008067 -> 0/0. Resolve with target 0x400. Refetch -> 1 / 0x400. Fetching alias 0x320 (same BTB index, different tag) -> 0/0.
- Checkpoint repair: fetch BRs at 0x100 then 0x104 (ghr shifts twice), then resolve 0x100 not-taken -> ghr = {stored[IDX-2:0], 0}, queue empty. A same-cycle fetch of 0x108 does not push or shift.
- Queue overflow: fetch 5 BRs, then resolve the first PC -> miss path uses current ghr. Saturation at 00/11 holds; reset mid-stream restores all reset values.

Source files
------------

// File: rtl/gshare_ongorucu.sv
// Gshare branch predictor: global-history-indexed 2-bit counters for BR, always-taken JAL,
// direct-mapped BTB for JALR, with per-branch history checkpoints repaired on resolution.
module gshare_ongorucu #(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 8,
  parameter int CKPT_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] getir_ps,
  input  logic [31:0] getir_buyruk,
  input  logic        getir_gecerli,
  input  logic [31:0] yurut_ps,
  input  logic [31:0] yurut_buyruk,
  input  logic        yurut_dallan,
  input  logic [31:0] yurut_dallan_ps,
  input  logic        yurut_gecerli,
  output logic        sonuc_dallan,
  output logic [31:0] sonuc_dallan_ps
);
  localparam int IDX  = $clog2(BHT_ENTRIES);
  localparam int BIDX = $clog2(BTB_ENTRIES);
  localparam int TAGW = 32 - BIDX - 2;
  localparam int CW   = $clog2(CKPT_DEPTH + 1);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]      r_bht       [BHT_ENTRIES];
  logic [IDX-1:0]  r_ghr;
  logic            r_btb_v     [BTB_ENTRIES];
  logic [TAGW-1:0] r_btb_etiket[BTB_ENTRIES];
  logic [31:0]     r_btb_hedef [BTB_ENTRIES];
  logic [31:0]     r_q_ps      [CKPT_DEPTH];
  logic [IDX-1:0]  r_q_ghr     [CKPT_DEPTH];
  logic [CW-1:0]   r_q_say;

  logic            w_g_br, w_g_jal, w_g_jalr;
  logic            w_y_br, w_y_jalr;
  logic [31:0]     w_imm_b, w_imm_j;
  logic [IDX-1:0]  w_g_idx;
  logic [BIDX-1:0] w_g_bidx, w_y_bidx;
  logic            w_btb_hit;
  logic            w_g_tahmin;
  logic            w_push;
  logic            w_q_dolu;
  logic            w_bulundu;
  logic [IDX-1:0]  w_hist;
  logic [IDX-1:0]  w_y_idx;
  logic [1:0]      w_ctr, w_ctr_yeni;
  logic            w_unused;

  assign w_unused = &{1'b0, yurut_buyruk[31:7]};

  assign w_g_br   = (getir_buyruk[6:0] == OP_BR);
  assign w_g_jal  = (getir_buyruk[6:0] == OP_JAL);
  assign w_g_jalr = (getir_buyruk[6:0] == OP_JALR);
  assign w_y_br   = (yurut_buyruk[6:0] == OP_BR);
  assign w_y_jalr = (yurut_buyruk[6:0] == OP_JALR);

  assign w_imm_b = {{20{getir_buyruk[31]}}, getir_buyruk[7], getir_buyruk[30:25],
                    getir_buyruk[11:8], 1'b0};
  assign w_imm_j = {{12{getir_buyruk[31]}}, getir_buyruk[19:12], getir_buyruk[20],
                    getir_buyruk[30:21], 1'b0};

  assign w_g_idx    = getir_ps[IDX+1:2] ^ r_ghr;
  assign w_g_bidx   = getir_ps[BIDX+1:2];
  assign w_y_bidx   = yurut_ps[BIDX+1:2];
  assign w_btb_hit  = r_btb_v[w_g_bidx] && (r_btb_etiket[w_g_bidx] == getir_ps[31:BIDX+2]);
  assign w_g_tahmin = r_bht[w_g_idx][1];

  always_comb begin
    sonuc_dallan    = 1'b0;
    sonuc_dallan_ps = 32'd0;
    if (getir_gecerli) begin
      if (w_g_br && w_g_tahmin) begin
        sonuc_dallan    = 1'b1;
        sonuc_dallan_ps = getir_ps + w_imm_b;
      end else if (w_g_jal) begin
        sonuc_dallan    = 1'b1;
        sonuc_dallan_ps = getir_ps + w_imm_j;
      end else if (w_g_jalr && w_btb_hit) begin
        sonuc_dallan    = 1'b1;
        sonuc_dallan_ps = r_btb_hedef[w_g_bidx];
      end
    end
  end

  // A resolution in the same cycle flushes the fetch, so it never checkpoints.
  assign w_push   = getir_gecerli && w_g_br && !yurut_gecerli;
  assign w_q_dolu = (r_q_say == CW'(CKPT_DEPTH));

  // Oldest-first search: index 0 is always the oldest live checkpoint.
  always_comb begin
    w_bulundu = 1'b0;
    w_hist    = r_ghr;
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      if (!w_bulundu && (i < int'(r_q_say)) && (r_q_ps[i] == yurut_ps)) begin
        w_bulundu = 1'b1;
        w_hist    = r_q_ghr[i];
      end
    end
  end

  assign w_y_idx = yurut_ps[IDX+1:2] ^ w_hist;
  assign w_ctr   = r_bht[w_y_idx];

  always_comb begin
    w_ctr_yeni = w_ctr;
    if (yurut_dallan) begin
      if (w_ctr != 2'b11) w_ctr_yeni = w_ctr + 2'd1;
    end else begin
      if (w_ctr != 2'b00) w_ctr_yeni = w_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
    end else if (yurut_gecerli && w_y_br) begin
      r_bht[w_y_idx] <= w_ctr_yeni;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb_v[i] <= 1'b0;
    end else if (yurut_gecerli && w_y_jalr) begin
      r_btb_v[w_y_bidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (yurut_gecerli && w_y_jalr) begin
      r_btb_etiket[w_y_bidx] <= yurut_ps[31:BIDX+2];
      r_btb_hedef[w_y_bidx]  <= yurut_dallan_ps;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ghr <= '0;
    end else if (yurut_gecerli) begin
      if (w_y_br) r_ghr <= {w_hist[IDX-2:0], yurut_dallan};
      else        r_ghr <= w_hist;
    end else if (w_push) begin
      r_ghr <= {r_ghr[IDX-2:0], w_g_tahmin};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q_say <= '0;
    end else if (yurut_gecerli) begin
      r_q_say <= '0;
    end else if (w_push && !w_q_dolu) begin
      r_q_say <= r_q_say + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      if (w_q_dolu) begin
        for (int i = 0; i < CKPT_DEPTH - 1; i++) begin
          r_q_ps[i]  <= r_q_ps[i+1];
          r_q_ghr[i] <= r_q_ghr[i+1];
        end
        r_q_ps[CKPT_DEPTH-1]  <= getir_ps;
        r_q_ghr[CKPT_DEPTH-1] <= r_ghr;
      end else begin
        for (int i = 0; i < CKPT_DEPTH; i++) begin
          if (i == int'(r_q_say)) begin
            r_q_ps[i]  <= getir_ps;
            r_q_ghr[i] <= r_ghr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gshare_ongorucu.sv
// Bench for gshare_ongorucu: directed scenarios plus random traffic, each cycle checked
// against an abstract predictor model (integer counters, SV queue of checkpoints).
module tb_gshare_ongorucu;
  localparam int NBHT = 64;
  localparam int NBTB = 8;
  localparam int NCK  = 4;
  localparam logic [31:0] I_BR   = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h0100006F;
  localparam logic [31:0] I_JALR = 32'h00008067;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] getir_ps, getir_buyruk, yurut_ps, yurut_buyruk, yurut_dallan_ps;
  logic        getir_gecerli, yurut_dallan, yurut_gecerli;
  logic        sonuc_dallan;
  logic [31:0] sonuc_dallan_ps;

  gshare_ongorucu dut (
    .clk(clk), .rstn(rstn),
    .getir_ps(getir_ps), .getir_buyruk(getir_buyruk), .getir_gecerli(getir_gecerli),
    .yurut_ps(yurut_ps), .yurut_buyruk(yurut_buyruk), .yurut_dallan(yurut_dallan),
    .yurut_dallan_ps(yurut_dallan_ps), .yurut_gecerli(yurut_gecerli),
    .sonuc_dallan(sonuc_dallan), .sonuc_dallan_ps(sonuc_dallan_ps)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] pc; int g; } ck_t;
  int          m_ctr [NBHT];
  int          m_ghr;
  bit          m_bv  [NBTB];
  logic [31:0] m_btag[NBTB];
  logic [31:0] m_bdat[NBTB];
  ck_t         m_q[$];

  logic        s_dal;
  logic [31:0] s_ps;

  function automatic int kind(input logic [31:0] i);
    if (i[6:0] == 7'b1100011) return 1;
    if (i[6:0] == 7'b1101111) return 2;
    if (i[6:0] == 7'b1100111) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    logic [31:0] v;
    v = (i[31] ? -32'd4096 : 32'd0) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
    return v;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    logic [31:0] v;
    v = (i[31] ? -32'd1048576 : 32'd0) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048
        + 32'(i[30:21]) * 2;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NBHT; k++) m_ctr[k] = 1;
    for (int k = 0; k < NBTB; k++) m_bv[k] = 0;
    m_ghr = 0;
    m_q.delete();
  endtask

  task automatic step(input bit rst, input bit gv, input logic [31:0] gps, input logic [31:0] gi,
                      input bit yv, input logic [31:0] yps, input logic [31:0] yi,
                      input bit yd, input logic [31:0] ydps);
    logic        e_d;
    logic [31:0] e_ps;
    int          hist, bi, ix;
    bit          hit;
    @(negedge clk);
    rstn = !rst; getir_gecerli = gv; getir_ps = gps; getir_buyruk = gi;
    yurut_gecerli = yv; yurut_ps = yps; yurut_buyruk = yi; yurut_dallan = yd;
    yurut_dallan_ps = ydps;
    #1;
    e_d = 0; e_ps = 0;
    if (gv) begin
      ix = ((gps / 4) ^ m_ghr) % NBHT;
      bi = (gps / 4) % NBTB;
      case (kind(gi))
        1: if (m_ctr[ix] >= 2) begin e_d = 1; e_ps = gps + imm_b(gi); end
        2: begin e_d = 1; e_ps = gps + imm_j(gi); end
        3: if (m_bv[bi] && m_btag[bi] == gps / (4 * NBTB)) begin e_d = 1; e_ps = m_bdat[bi]; end
        default: ;
      endcase
    end
    s_dal = sonuc_dallan; s_ps = sonuc_dallan_ps;
    if (!rst) begin
      chk("dallan", {31'd0, sonuc_dallan}, {31'd0, e_d});
      chk("hedef", sonuc_dallan_ps, e_ps);
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (yv) begin
      hit = 0; hist = m_ghr;
      foreach (m_q[k]) if (!hit && m_q[k].pc == yps) begin hit = 1; hist = m_q[k].g; end
      case (kind(yi))
        1: begin
          ix = ((yps / 4) ^ hist) % NBHT;
          if (yd && m_ctr[ix] < 3) m_ctr[ix]++;
          if (!yd && m_ctr[ix] > 0) m_ctr[ix]--;
          m_ghr = (hist * 2 + int'(yd)) % NBHT;
        end
        3: begin
          bi = (yps / 4) % NBTB;
          m_bv[bi] = 1; m_btag[bi] = yps / (4 * NBTB); m_bdat[bi] = ydps;
          m_ghr = hist;
        end
        default: m_ghr = hist;
      endcase
      m_q.delete();
    end else if (gv && kind(gi) == 1) begin
      ck_t c;
      c.pc = gps; c.g = m_ghr;
      if (m_q.size() == NCK) void'(m_q.pop_front());
      m_q.push_back(c);
      m_ghr = (m_ghr * 2 + int'(e_d)) % NBHT;
    end
  endtask

  task automatic f(input logic [31:0] ps, input logic [31:0] i);
    step(0, 1, ps, i, 0, 0, 0, 0, 0);
  endtask

  task automatic r(input logic [31:0] ps, input logic [31:0] i, input bit d, input logic [31:0] t);
    step(0, 0, 0, 0, 1, ps, i, d, t);
  endtask

  task automatic lit(input string tag, input logic d, input logic [31:0] ps);
    chk({tag, "_d"}, {31'd0, s_dal}, {31'd0, d});
    chk({tag, "_ps"}, s_ps, ps);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5)      v = {v[31:7], 7'b1100011};
    else if (k < 6) v = {v[31:7], 7'b1101111};
    else if (k < 8) v = {v[31:7], 7'b1100111};
    else if (k < 9) v = {v[31:7], 7'b0010011};
    return v;
  endfunction

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 3) == 0) return 32'h300 + 32'($urandom_range(0, 3)) * 32'h20;
    return 32'h100 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Cold BR predicts not-taken; JAL always taken
    f(32'h100, I_BR);   lit("br_cold", 0, 0);
    f(32'h200, I_JAL);  lit("jal", 1, 32'h210);

    // Train counter at index 0 up to taken, walking history back to 0 between reports
    r(32'h100, I_BR, 1, 32'h108);
    for (int k = 0; k < 6; k++) f(32'h11C, I_BR);
    f(32'h100, I_BR);   lit("br_weak_t", 1, 32'h108);
    r(32'h100, I_BR, 1, 32'h108);
    for (int k = 0; k < 6; k++) f(32'h11C, I_BR);
    f(32'h100, I_BR);   lit("br_strong_t", 1, 32'h108);
    r(32'h100, I_BR, 1, 32'h108);
    f(32'h200, I_JAL);  lit("jal2", 1, 32'h210);

    // JALR through BTB, then an aliasing PC with a different tag
    f(32'h300, I_JALR); lit("jalr_miss", 0, 0);
    r(32'h300, I_JALR, 1, 32'h400);
    f(32'h300, I_JALR); lit("jalr_hit", 1, 32'h400);
    f(32'h320, I_JALR); lit("jalr_alias", 0, 0);

    // Checkpoint repair with a same-cycle fetch that must not push
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    f(32'h100, I_BR); f(32'h104, I_BR);
    step(0, 1, 32'h108, I_BR, 1, 32'h100, I_BR, 0, 0);
    for (int k = 0; k < 3; k++) f(32'h100 + 32'(k) * 4, I_BR);

    // Queue overflow: first PC is dropped, resolution falls back to live history
    for (int k = 0; k < 5; k++) f(32'h100 + 32'(k) * 4, I_BR);
    r(32'h100, I_BR, 1, 0);
    for (int k = 0; k < 5; k++) f(32'h100 + 32'(k) * 4, I_BR);

    // Saturation at 00
    for (int k = 0; k < 5; k++) r(32'h140, I_BR, 0, 0);
    r(32'h140, I_BR, 1, 0);
    f(32'h140, I_BR);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      bit          gv, yv, yd;
      logic [31:0] yps, yi;
      gv  = ($urandom_range(0, 3) != 0);
      yv  = ($urandom_range(0, 3) == 0);
      yd  = $urandom_range(0, 1) == 1;
      yps = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ?
            m_q[$urandom_range(0, m_q.size() - 1)].pc : rnd_pc();
      yi  = rnd_instr();
      step(0, gv, rnd_pc(), rnd_instr(), yv, yps, yi, yd, $urandom);
    end

    // Reset mid-stream with traffic on both ports
    step(1, 1, 32'h100, I_BR, 1, 32'h300, I_JALR, 1, 32'h500);
    f(32'h100, I_BR);   lit("rst_br", 0, 0);
    f(32'h300, I_JALR); lit("rst_jalr", 0, 0);
    f(32'h200, I_JAL);  lit("rst_jal", 1, 32'h210);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
